// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: fixed priority from index 0, or a
// rotating search that starts at ptr and wraps modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int MODE  = MODE_FIXED,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gidx
);

  // Walk the N candidates from the start index; the first requester wins.
  always_comb begin
    int   start;
    int   idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    start = (MODE == MODE_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input registered stream multiplexer with valid/ready on every channel.
// One arbitrated channel per cycle is captured into a single output stage.
module stream_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  parameter  int MODE  = MODE_FIXED,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [N-1:0]            grant;
  logic [SEL_W-1:0]        gidx;
  logic [SEL_W-1:0]        rr_ptr;
  logic [SEL_W-1:0]        rr_nxt;
  logic [N-1:0][WIDTH-1:0] masked;
  logic [WIDTH-1:0]        sel_data;
  logic                    load;

  rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  // Output stage can accept when empty or being drained this cycle.
  assign load     = !out_valid || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;

  // Pointer advances past the winner; explicit wrap keeps it below N.
  assign rr_nxt = (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;

  // Per-channel gating for the AND-OR select; grant is one-hot.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign masked[i] = in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}};
  end

  // OR-reduce the gated lanes into the selected beat.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) sel_data = sel_data | masked[i];
  end

  // Output register and round-robin pointer; hold everything under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (|in_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gidx;
        if (MODE == MODE_RR) rr_ptr <= rr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: three instances (fixed N=3, round-robin N=3,
// round-robin N=5) checked every cycle against a behavioural model,
// plus directed literal expectations.
module tb_stream_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   iv   [3];
  logic [159:0] id   [3];
  logic         ordy [3];

  logic [2:0]  ir0, ir1;
  logic [4:0]  ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  os0, os1;
  logic [2:0]  os2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(32), .N(3), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0][2:0]), .in_data(id[0][95:0]),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0]));
  stream_mux #(.WIDTH(32), .N(3), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1][2:0]), .in_data(id[1][95:0]),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1]));
  stream_mux #(.WIDTH(32), .N(5), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(id[2]),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2]));

  // ---------------- behavioural model ----------------
  int          mode_of [3] = '{0, 1, 1};
  int          n_of    [3] = '{3, 3, 5};
  logic        mv [3];
  logic [31:0] md [3];
  int          ms [3];
  int          mp [3];
  logic        armed = 1'b0;

  // First requesting channel met when scanning from the start point.
  function automatic int winner(input int u);
    int start = (mode_of[u] == 1) ? mp[u] : 0;
    for (int k = 0; k < n_of[u]; k++) begin
      int c = (start + k) % n_of[u];
      if (iv[u][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [4:0] exp_ready(input int u);
    int w = winner(u);
    if (!rst_n || !(!mv[u] || ordy[u]) || w < 0) return 5'd0;
    return 5'(1 << w);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (!rst_n) begin
        mv[u] <= 1'b0; md[u] <= '0; ms[u] <= 0; mp[u] <= 0;
      end else if (!mv[u] || ordy[u]) begin
        if (winner(u) >= 0) begin
          mv[u] <= 1'b1;
          md[u] <= id[u][winner(u)*32 +: 32];
          ms[u] <= winner(u);
          if (mode_of[u] == 1) mp[u] <= (winner(u) + 1) % n_of[u];
        end else begin
          mv[u] <= 1'b0;
        end
      end
    end
    if (!rst_n) armed <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_unit(input int u, input logic [4:0] ir, input logic ov,
                          input logic [31:0] od, input logic [2:0] os);
    string s;
    s = $sformatf("u%0d", u);
    chk({s, ".in_ready"},  {27'd0, ir}, {27'd0, exp_ready(u)});
    chk({s, ".out_valid"}, {31'd0, ov}, {31'd0, mv[u]});
    chk({s, ".out_data"},  od, md[u]);
    chk({s, ".out_sel"},   {29'd0, os}, 32'(ms[u]));
  endtask

  // Per-cycle comparison on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (armed) begin
      cmp_unit(0, {2'b0, ir0}, ov0, od0, {1'b0, os0});
      cmp_unit(1, {2'b0, ir1}, ov1, od1, {1'b0, os1});
      cmp_unit(2, ir2, ov2, od2, os2);
      chk("u1.rr_ptr", {30'd0, u1.rr_ptr}, 32'(mp[1]));
      chk("u2.rr_ptr", {29'd0, u2.rr_ptr}, 32'(mp[2]));
      chk("u2.rr_ptr_range", {31'd0, (u2.rr_ptr < 3'd5)}, 32'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      iv[u] = 5'b11111; id[u] = '0; ordy[u] = 1'b1;
    end
    id[0][0 +: 32] = 32'hA0A0A0A0;

    // Reset held for two cycles with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst.ov0", {31'd0, ov0}, 32'd0);
      chk("rst.od0", od0, 32'd0);
      chk("rst.os0", {30'd0, os0}, 32'd0);
      chk("rst.ir0", {29'd0, ir0}, 32'd0);
      chk("rst.ir2", {27'd0, ir2}, 32'd0);
    end
    rst_n = 1'b1;
    for (int u = 0; u < 3; u++) iv[u] = '0;
    tick();

    // Fixed priority: ch1 beats ch2 until it drops valid.
    id[0][32 +: 32] = 32'h11111111;
    id[0][64 +: 32] = 32'h22222222;
    iv[0] = 5'b00110;
    tick();
    chk("fp.sel1", {30'd0, os0}, 32'd1);
    chk("fp.data1", od0, 32'h11111111);
    tick();
    chk("fp.sel1_again", {30'd0, os0}, 32'd1);
    iv[0] = 5'b00100;
    tick();
    chk("fp.sel2", {30'd0, os0}, 32'd2);
    chk("fp.data2", od0, 32'h22222222);
    iv[0] = '0;
    tick();
    chk("fp.drain", {31'd0, ov0}, 32'd0);

    // Round-robin over three always-valid channels.
    id[1][0 +: 32]  = 32'h00000000;
    id[1][32 +: 32] = 32'h11111111;
    id[1][64 +: 32] = 32'h22222222;
    iv[1] = 5'b00111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr.valid", {31'd0, ov1}, 32'd1);
      chk("rr.sel", {30'd0, os1}, 32'(k % 3));
    end
    iv[1] = '0;
    tick();
    chk("rr.drain", {31'd0, ov1}, 32'd0);

    // Back-pressure: output held while the consumer stalls.
    id[0][0 +: 32] = 32'hDEADBEEF;
    iv[0] = 5'b00001;
    tick();
    chk("bp.load", od0, 32'hDEADBEEF);
    ordy[0] = 1'b0;
    id[0][0 +: 32] = 32'h0BADF00D;
    iv[0] = 5'b00011;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp.hold_data", od0, 32'hDEADBEEF);
      chk("bp.hold_sel", {30'd0, os0}, 32'd0);
      chk("bp.ready_low", {29'd0, ir0}, 32'd0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp.ready_on_release", {29'd0, ir0}, 32'd1);
    tick();
    chk("bp.new_beat", od0, 32'h0BADF00D);
    iv[0] = '0;
    tick();

    // Idle drain: one beat on ch2, then nothing.
    iv[1] = 5'b00100;
    tick();
    chk("idle.valid", {31'd0, ov1}, 32'd1);
    chk("idle.sel", {30'd0, os1}, 32'd2);
    iv[1] = '0;
    tick();
    chk("idle.valid_low", {31'd0, ov1}, 32'd0);
    chk("idle.data_hold", od1, 32'h22222222);
    chk("idle.ptr", {30'd0, u1.rr_ptr}, 32'd0);
    tick();
    chk("idle.still_low", {31'd0, ov1}, 32'd0);

    // Five-channel round-robin wrap.
    for (int c = 0; c < 5; c++) id[2][c*32 +: 32] = {8{c[3:0]}};
    iv[2] = 5'b10000;
    tick();
    chk("n5.sel4", {29'd0, os2}, 32'd4);
    chk("n5.ptr0", {29'd0, u2.rr_ptr}, 32'd0);
    iv[2] = 5'b01001;
    tick();
    chk("n5.sel0", {29'd0, os2}, 32'd0);
    chk("n5.ptr1", {29'd0, u2.rr_ptr}, 32'd1);
    iv[2] = 5'b01000;
    tick();
    chk("n5.sel3", {29'd0, os2}, 32'd3);
    chk("n5.data3", od2, 32'h33333333);
    chk("n5.ptr4", {29'd0, u2.rr_ptr}, 32'd4);
    iv[2] = 5'b00011;
    tick();
    chk("n5.wrap_sel0", {29'd0, os2}, 32'd0);
    iv[2] = '0;
    tick();

    // Reset drops a beat that is in flight.
    iv[0] = 5'b00111;
    tick();
    chk("mid.valid", {31'd0, ov0}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid.rst_valid", {31'd0, ov0}, 32'd0);
    chk("mid.rst_data", od0, 32'd0);
    chk("mid.rst_ready", {29'd0, ir0}, 32'd0);
    rst_n = 1'b1;
    iv[0] = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
